kim_arb_mux_nto1: RTL and testbench

KIM_ARB_MUX_NTO1 -- requirements
Module: kim_arb_mux_nto1

---
 rtl/kim_mux_pkg.sv | 25 ++
 rtl/kim_rr_arbiter.sv | 17 +
 rtl/kim_arb_mux_nto1.sv | 145 ++++++++++++++
 tb/tb_kim_arb_mux_nto1.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/kim_mux_pkg.sv
// Shared constants and the round-robin grant search used by the N:1 arbitrated mux.
package kim_mux_pkg;

  // Mode encoding for the mode_fixed input
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Largest channel count the grant search supports
  localparam int unsigned MAX_CH = 16;

  // First requester at or after (last+1) mod n, wrapping; returns n when nobody requests
  function automatic int unsigned rr_grant_search(input logic [MAX_CH-1:0] req,
                                                  input int unsigned       last,
                                                  input int unsigned       n);
    int unsigned idx;
    int unsigned res;
    res = n;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = (last + i) % n;
      if ((i <= n) && (res == n) && req[4'(idx)]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/kim_rr_arbiter.sv
// Combinational round-robin grant: first requester after last_grant, with wrap.
module kim_rr_arbiter
  import kim_mux_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  assign grant_valid = (rr_grant_search(MAX_CH'(req), 32'(last_grant), NUM_CH) < NUM_CH);
  assign grant       = SEL_WIDTH'(rr_grant_search(MAX_CH'(req), 32'(last_grant), NUM_CH));

endmodule

// File: rtl/kim_arb_mux_nto1.sv
// N:1 arbitrated mux with a registered output word, round-robin or fixed select.
// Optional KIM_ARB_MUX_SKID_EN adds a skid register so in_ready depends only on
// registered state (no combinational out_ready -> in_ready path).
module kim_arb_mux_nto1
  import kim_mux_pkg::*;
#(
  parameter int unsigned MUX_DATA_WIDTH = 32,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SEL_WIDTH      = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode_fixed,
  input  logic [SEL_WIDTH-1:0]             fixed_sel,
  input  logic [NUM_CH-1:0]                in_valid,
  input  logic [NUM_CH*MUX_DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]                in_ready,
  output logic                             out_valid,
  output logic [MUX_DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]             out_sel,
  input  logic                             out_ready
);

  logic [SEL_WIDTH-1:0]      r_last_grant;
  logic                      r_out_valid;
  logic [MUX_DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]      r_out_sel;

  logic [SEL_WIDTH-1:0]      w_rr_grant;
  logic                      w_rr_valid;
  logic                      w_fix_ok;
  logic [SEL_WIDTH-1:0]      w_grant;
  logic                      w_grant_valid;
  logic                      w_free;
  logic                      w_accept;
  logic [MUX_DATA_WIDTH-1:0] w_in_word;
  logic [NUM_CH-1:0]         w_in_ready;

  kim_rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr (
    .req         (in_valid),
    .last_grant  (r_last_grant),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  // Fixed-select eligibility; an out-of-range fixed_sel matches no channel
  always_comb begin
    w_fix_ok = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (fixed_sel == SEL_WIDTH'(k)) w_fix_ok = in_valid[k];
    end
  end

  assign w_grant       = (mode_fixed == MODE_FIXED) ? fixed_sel : w_rr_grant;
  assign w_grant_valid = (mode_fixed == MODE_FIXED) ? w_fix_ok  : w_rr_valid;
  assign w_accept      = w_grant_valid && w_free;

  // Word mux and one-hot ready for the granted channel; ready is held low during reset
  always_comb begin
    w_in_word  = '0;
    w_in_ready = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_grant == SEL_WIDTH'(k)) begin
        w_in_word = in_data[k*MUX_DATA_WIDTH +: MUX_DATA_WIDTH];
        if (w_accept && !rst) w_in_ready[k] = 1'b1;
      end
    end
  end

  // Round-robin pointer moves only on accepted round-robin transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= SEL_WIDTH'(NUM_CH - 1);
    end else if (w_accept && (mode_fixed == MODE_RR)) begin
      r_last_grant <= w_grant;
    end
  end

`ifdef KIM_ARB_MUX_SKID_EN
  logic                      r_skid_valid;
  logic [MUX_DATA_WIDTH-1:0] r_skid_data;
  logic [SEL_WIDTH-1:0]      r_skid_sel;
  logic                      w_out_open;

  assign w_free     = !r_skid_valid;
  assign w_out_open = !r_out_valid || out_ready;

  // Output register backed by one skid slot; the skid word always goes out first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_sel   <= '0;
    end else if (r_skid_valid) begin
      if (w_out_open) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_sel    <= r_skid_sel;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_out_open) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_in_word;
        r_out_sel   <= w_grant;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_in_word;
        r_skid_sel   <= w_grant;
      end
    end else if (w_out_open) begin
      r_out_valid <= 1'b0;
    end
  end
`else
  assign w_free = !r_out_valid || out_ready;

  // Single output register; load on accept, otherwise empty once drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_in_word;
      r_out_sel   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_kim_arb_mux_nto1.sv
// Directed self-checking bench for kim_arb_mux_nto1 with an expected-word scoreboard.
module tb_kim_arb_mux_nto1;

`ifdef KIM_ARB_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode_fixed;
  logic [1:0]  fixed_sel;
  logic [3:0]  in_valid;
  logic [31:0] ch_data [4];
  logic [127:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic        mode5;
  logic [2:0]  fsel5;
  logic [4:0]  in_valid5;
  logic [39:0] in_data5;
  logic [4:0]  in_ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic [2:0]  out_sel5;
  logic        out_ready5;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  kim_arb_mux_nto1 #(.MUX_DATA_WIDTH(32), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  kim_arb_mux_nto1 #(.MUX_DATA_WIDTH(8), .NUM_CH(5)) dut5 (
    .clk(clk), .rst(rst), .mode_fixed(mode5), .fixed_sel(fsel5),
    .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_sel(out_sel5), .out_ready(out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k);
    sb.push_back('{sel: 2'(k), data: ch_data[k]});
  endtask

  // Check ready and any word leaving at the coming edge, then move past that edge
  task automatic tick(input logic [3:0] exp_rdy);
    sb_entry_t e;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty_on_drain", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_sel", 32'(out_sel), 32'(e.sel));
        chk("out_data", out_data, e.data);
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] rdy;
    mode_fixed = 1'b0;
    fixed_sel  = 2'd0;
    in_valid   = 4'b1111;
    out_ready  = 1'b1;
    for (int k = 0; k < 4; k++) ch_data[k] = 32'hC0DE_0000 | 32'(k);
    mode5      = 1'b0;
    fsel5      = 3'd0;
    in_valid5  = 5'b0;
    in_data5   = 40'h44_33_22_11_00;
    out_ready5 = 1'b1;

    // Reset state, with requests pending
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // All channels valid: strict rotation from channel 0
    for (int i = 0; i < 8; i++) begin
      push(i % 4);
      tick(4'(1 << (i % 4)));
    end
    in_valid = 4'b0000;
    tick(4'b0000);
    chk("rr_drained", 32'(sb.size()), 32'd0);

    // Sparse requests 1010 starting from last_grant=3
    in_valid = 4'b1010;
    push(1); tick(4'b0010);
    push(3); tick(4'b1000);
    push(1); tick(4'b0010);
    push(3); tick(4'b1000);
    in_valid = 4'b0000;
    tick(4'b0000);
    chk("sparse_drained", 32'(sb.size()), 32'd0);

    // Backpressure: held word stable, skid takes exactly one extra word
    in_valid = 4'b1111;
    push(0); tick(4'b0001);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy = 4'b0000;
      if (SKID && i == 0) begin
        rdy = 4'b0010;
        push(1);
      end
      tick(rdy);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sel", 32'(out_sel), 32'd0);
      chk("hold_data", out_data, ch_data[0]);
    end
    out_ready = 1'b1;
    if (!SKID) push(1);
    tick(SKID ? 4'b0000 : 4'b0010);
    in_valid = 4'b0000;
    tick(4'b0000);
    tick(4'b0000);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Fixed select on channel 2
    ch_data[2] = 32'hDEADBEEF;
    mode_fixed = 1'b1;
    fixed_sel  = 2'd2;
    in_valid   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push(2);
      tick(4'b0100);
      chk("fixed_data", out_data, 32'hDEADBEEF);
      chk("fixed_sel_out", 32'(out_sel), 32'd2);
    end
    // Mode change while a word is held leaves it untouched
    out_ready  = 1'b0;
    in_valid   = 4'b0000;
    mode_fixed = 1'b0;
    fixed_sel  = 2'd0;
    tick(4'b0000);
    chk("modechg_data", out_data, 32'hDEADBEEF);
    chk("modechg_sel", 32'(out_sel), 32'd2);
    // Fixed channel not valid: nothing granted
    mode_fixed = 1'b1;
    fixed_sel  = 2'd1;
    in_valid   = 4'b1101;
    out_ready  = 1'b1;
    tick(4'b0000);
    chk("fixed_idle_valid", 32'(out_valid), 32'd0);
    // Back to round-robin: pointer held at 1 through fixed mode
    mode_fixed = 1'b0;
    in_valid   = 4'b1111;
    push(2); tick(4'b0100);
    in_valid = 4'b0000;
    tick(4'b0000);
    chk("fixed_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-stream
    in_valid = 4'b1111;
    push(3); tick(4'b1000);
    push(0); tick(4'b0001);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_sel", 32'(out_sel), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    push(0); tick(4'b0001);
    in_valid = 4'b0000;
    tick(4'b0000);
    chk("arst_drained", 32'(sb.size()), 32'd0);

    // Five-channel instance: out-of-range fixed_sel grants nothing
    mode5     = 1'b1;
    fsel5     = 3'd5;
    in_valid5 = 5'b11111;
    #1;
    chk("sel5_ready", 32'(in_ready5), 32'd0);
    tick(4'b0000);
    chk("sel5_out_valid", 32'(out_valid5), 32'd0);
    fsel5 = 3'd7;
    #1;
    chk("sel7_ready", 32'(in_ready5), 32'd0);
    fsel5 = 3'd4;
    #1;
    chk("sel4_ready", 32'(in_ready5), 32'b10000);
    tick(4'b0000);
    chk("sel4_out_valid", 32'(out_valid5), 32'd1);
    chk("sel4_out_sel", 32'(out_sel5), 32'd4);
    chk("sel4_out_data", 32'(out_data5), 32'h44);
    in_valid5 = 5'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
